// File: rtl/beep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : beep_pkg
//  Purpose  : Shared constants and state encoding for the ~1 kHz beep tone
//             generator and detector (48 MHz clock).
//  Revision : 1.0  initial release
// ============================================================================
package beep_pkg;

  // Half period of the generated tone in clk cycles (counter terminal value)
  localparam int BEEP_HALF_CNT = 24000;
  // Full tone period: each half lasts BEEP_HALF_CNT+1 cycles
  localparam int NOM_PERIOD    = 2 * (BEEP_HALF_CNT + 1);
  // Accepted deviation, +/-1 % of the nominal period
  localparam int TOL           = NOM_PERIOD / 100;
  // Consecutive good periods before the tone is declared present
  localparam int LOCK_N        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/beep_detect_if.sv
`default_nettype none
// ============================================================================
//  Module   : beep_detect_if
//  Purpose  : Tone input and measurement outputs of the beep detector.
//             master = tone source / consumer, slave = detector.
//  Revision : 1.0  initial release
// ============================================================================
interface beep_detect_if;

  logic        tone_in;
  logic        tone_present;
  logic [31:0] period;
  logic        period_valid;

  modport master (
    output tone_in,
    input  tone_present,
    input  period,
    input  period_valid
  );

  modport slave (
    input  tone_in,
    output tone_present,
    output period,
    output period_valid
  );

endinterface
`default_nettype wire

// File: rtl/beep_detect_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//             rising-edge detector. rise_pulse is high for one cycle when the
//             synchronized value is 1 and its previous value was 0.
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic async_in,
  output logic      rise_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_pulse = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/beep_detect.sv
`default_nettype none
// ============================================================================
//  Module   : beep_detect
//  Purpose  : Measures the period of an asynchronous square-wave beep and
//             declares the tone present after LOCK_N consecutive periods
//             inside NOM_PERIOD +/- TOL. Every measured period (after the
//             arming edge) is reported with a one-cycle period_valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module beep_detect #(
  parameter int NOM_PERIOD = beep_pkg::NOM_PERIOD,
  parameter int TOL        = beep_pkg::TOL,
  parameter int LOCK_N     = beep_pkg::LOCK_N
) (
  input wire logic     clk,
  input wire logic     rst,
  beep_detect_if.slave bus
);

  import beep_pkg::*;

  localparam int          GW       = $clog2(LOCK_N + 1);
  localparam logic [31:0] WIN_LO   = 32'(NOM_PERIOD - TOL);
  localparam logic [31:0] WIN_HI   = 32'(NOM_PERIOD + TOL);
  localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_N);

  logic          rise;
  logic [31:0]   meas;
  logic          in_win;
  logic [GW-1:0] good_inc;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [31:0]   period_q, period_d;
  logic          period_valid_q, period_valid_d;
  logic          tone_present_q, tone_present_d;

  sync_edge u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .async_in   (bus.tone_in),
    .rise_pulse (rise)
  );

  // Period that would be reported if an edge occurs in this cycle; only
  // consulted in MEASURE/LOCKED, where cnt never exceeds WIN_HI.
  assign meas     = cnt_q + 32'd1;
  assign in_win   = (meas >= WIN_LO) && (meas <= WIN_HI);
  assign good_inc = good_cnt_q + GW'(1);

  // Next-state logic: cycle counter, lock FSM and registered outputs
  always_comb begin
    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;

    // Counter clears on every edge and otherwise saturates at all-ones
    if (rise) begin
      cnt_d = 32'd0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        good_cnt_d = '0;
        // First edge only provides the timing reference
        if (rise) begin
          state_d = MEASURE;
        end
      end

      MEASURE, LOCKED: begin
        if (rise) begin
          // Edge wins over a coincident timeout: it is simply out of window
          period_valid_d = 1'b1;
          period_d       = meas;
          if (in_win) begin
            if (state_q == LOCKED) begin
              good_cnt_d = LOCK_CNT;
            end else if (good_inc == LOCK_CNT) begin
              state_d    = LOCKED;
              good_cnt_d = LOCK_CNT;
            end else begin
              good_cnt_d = good_inc;
            end
          end else begin
            state_d    = MEASURE;
            good_cnt_d = '0;
          end
        end else if (cnt_q >= WIN_HI) begin
          // No edge within the longest acceptable period: tone is gone
          state_d    = IDLE;
          good_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
      end
    endcase

    tone_present_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 32'd0;
      good_cnt_q     <= '0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
      tone_present_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_cnt_q     <= good_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      tone_present_q <= tone_present_d;
    end
  end

  assign bus.tone_present = tone_present_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_beep_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beep_detect
//  Purpose  : Self-checking bench for beep_detect, run with a scaled-down
//             nominal period (100 +/- 10 cycles, lock after 4 good periods).
//  Revision : 1.0  initial release
// ============================================================================
module tb_beep_detect;

  localparam int NOM   = 100;
  localparam int TOLR  = 10;
  localparam int LOCKN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  beep_detect_if bus ();

  beep_detect #(
    .NOM_PERIOD (NOM),
    .TOL        (TOLR),
    .LOCK_N     (LOCKN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Count period_valid pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.period_valid === 1'b1) pulses++;
  end

  typedef struct {
    bit rst_first;
    int gap;
    int dpulse;
    int per;
    bit tone;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input int g, input int d, input int p, input bit t);
    vec_t v;
    v.rst_first = r;
    v.gap       = g;
    v.dpulse    = d;
    v.per       = p;
    v.tone      = t;
    vq.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("reset tone_present", 32'(bus.tone_present), 32'd0);
    chk("reset period", bus.period, 32'd0);
    chk("reset period_valid", 32'(bus.period_valid), 32'd0);
  endtask

  // Rising edge of tone_in 'gap' cycles after the previous one; returns
  // 5 cycles after the rise, once its measurement has been registered.
  task automatic rise_after(input int gap);
    tick(gap - 5);
    bus.tone_in = 1'b1;
    tick(3);
    bus.tone_in = 1'b0;
    tick(2);
  endtask

  task automatic apply_vec(input int i);
    int p0;
    if (vq[i].rst_first) do_reset();
    p0 = pulses;
    rise_after(vq[i].gap);
    chk($sformatf("v%0d pulses", i), 32'(pulses - p0), 32'(vq[i].dpulse));
    if (vq[i].dpulse != 0)
      chk($sformatf("v%0d period", i), bus.period, 32'(vq[i].per));
    chk($sformatf("v%0d tone_present", i), 32'(bus.tone_present), 32'(vq[i].tone));
  endtask

  initial begin
    int p0;
    bus.tone_in = 1'b0;

    // Nominal tone: 6 edges, 5 measurements, lock on the 4th good period
    add(1, 20, 0, 0, 0);
    repeat (3) add(0, 100, 1, 100, 0);
    add(0, 100, 1, 100, 1);
    add(0, 100, 1, 100, 1);
    // Period one above the window; every edge lands on the timeout cycle
    add(1, 20, 0, 0, 0);
    repeat (8) add(0, 111, 1, 111, 0);
    // Window limits alternate, then one short period breaks the lock
    add(1, 20, 0, 0, 0);
    add(0, 90, 1, 90, 0);
    add(0, 110, 1, 110, 0);
    add(0, 90, 1, 90, 0);
    add(0, 110, 1, 110, 1);
    add(0, 89, 1, 89, 0);
    repeat (3) add(0, 100, 1, 100, 0);
    add(0, 100, 1, 100, 1);

    tick(3);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) apply_vec(i);

    // Locked, tone stops: drop exactly when cnt reaches NOM+TOL
    p0 = pulses;
    tick(108);
    chk("timeout before limit tone_present", 32'(bus.tone_present), 32'd1);
    tick(1);
    chk("timeout tone_present", 32'(bus.tone_present), 32'd0);
    chk("timeout no pulse", 32'(pulses - p0), 32'd0);
    p0 = pulses;
    rise_after(50);
    chk("after timeout edge only arms", 32'(pulses - p0), 32'd0);

    // Reset while locked aborts the lock; relock takes LOCK_N+1 edges
    do_reset();
    rise_after(20);
    repeat (4) rise_after(100);
    chk("pre-reset locked", 32'(bus.tone_present), 32'd1);
    tick(30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid reset tone_present", 32'(bus.tone_present), 32'd0);
    chk("mid reset period", bus.period, 32'd0);
    chk("mid reset period_valid", 32'(bus.period_valid), 32'd0);
    p0 = pulses;
    rise_after(100);
    chk("post reset arm pulses", 32'(pulses - p0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rise_after(100);
      chk($sformatf("relock %0d tone_present", k), 32'(bus.tone_present), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("relock period", bus.period, 32'd100);

    // tone_in high at reset release gives only an arming edge
    bus.tone_in = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    p0 = pulses;
    tick(6);
    bus.tone_in = 1'b0;
    chk("high at release no pulse", 32'(pulses - p0), 32'd0);
    chk("high at release tone_present", 32'(bus.tone_present), 32'd0);
    rise_after(60);
    chk("high at release armed", 32'(pulses - p0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beep_detect.md
BEEP_DETECT -- requirements
Module: beep_detect

Interface
REQ-001 Parameter NOM_PERIOD, 48002, nominal tone period in clk cycles (2 x (24000+1); 48 MHz clock, ~1 kHz tone).
REQ-002 Parameter TOL, 480, accepted deviation in cycles (±1 %); window is NOM_PERIOD-TOL .. NOM_PERIOD+TOL inclusive (47522..48482).
REQ-003 Parameter LOCK_N, 4, number of consecutive in-window periods required to declare the tone present.
REQ-004 clk  input  1  system clock, 48 MHz, single clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tone_in  input  1  asynchronous square-wave beep signal to be detected.
REQ-007 tone_present  output  1  registered; high while a valid locked tone is detected.
REQ-008 period  output  32  last measured period in clk cycles; holds until the next measurement.
REQ-009 period_valid  output  1  one-cycle pulse, asserted in the same cycle period updates.

Function
REQ-010 tone_in shall pass through a 2-flop synchronizer; a rising edge is detected when the synchronized value is 1 and its registered previous value is 0 (3 cycles of input-to-edge latency).
REQ-011 A 32-bit cycle counter cnt shall clear to 0 in the edge cycle and increment by 1 in every other cycle; measured period = cnt+1 at an edge.
REQ-012 States: IDLE (no reference edge), MEASURE (armed, unlocked) and LOCKED; there is also a good-period count good_cnt in the range 0..LOCK_N.
REQ-013 IDLE: an edge only arms the detector; go to MEASURE; no period_valid; good_cnt=0.
REQ-014 MEASURE/LOCKED: every edge shall produce period_valid=1 and period=cnt+1 on the next cycle, whether the period is inside or outside the window.
REQ-015 MEASURE, in-window edge: good_cnt+1; when it reaches LOCK_N, go to LOCKED and assert tone_present on the next cycle.
REQ-016 MEASURE, out-of-window edge: good_cnt=0; stay in MEASURE (the edge re-arms).
REQ-017 LOCKED, in-window edge: stay in LOCKED; tone_present stays 1.
REQ-018 LOCKED, out-of-window edge: go to MEASURE with good_cnt=0; tone_present goes to 0 on the next cycle.
REQ-019 Timeout: in MEASURE or LOCKED, if cnt reaches NOM_PERIOD+TOL with no edge, go to IDLE with good_cnt=0; tone_present goes to 0 on the next cycle.
REQ-020 Edge in the same cycle as the timeout: the edge wins; period NOM_PERIOD+TOL+1 is reported, it is out of window, and the block goes to MEASURE.
REQ-021 cnt shall saturate at all-ones; it shall never wrap.
REQ-022 tone_present depends only on state (LOCKED = 1); there are no combinational paths from tone_in to outputs.

Reset
REQ-023 Under rst: synchronizer and edge flops = 0, cnt = 0, good_cnt = 0, state = IDLE, tone_present = 0, period = 0, period_valid = 0, all on the next clk edge.
REQ-024 rst asserted mid-operation shall abort any lock at once; after release, relock needs LOCK_N+1 edges.
REQ-025 If tone_in is high at reset release, the resulting edge is treated as a first (arming) edge only.

Structure
REQ-026 The shared package beep_pkg shall hold BEEP_HALF_CNT = 24000, the derived NOM_PERIOD, TOL, and the state enum (IDLE, MEASURE, LOCKED), for use by tone generator and detector alike.
REQ-027 One sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse), shall be instantiated; the rest is one FSM/counter block.

Verification
REQ-028 Scenario: square wave with period 48002, 6 rising edges -> 5 period_valid pulses with period=48002; tone_present rises the cycle after the 5th edge's measurement.
REQ-029 Scenario: period 48483 repeated 8 times -> period=48483 on each pulse; tone_present stays 0.
REQ-030 Scenario: periods 47522 and 48482 alternating -> lock achieved; then one 47521 period -> tone_present drops and 4 more good periods are needed to relock.
REQ-031 Scenario: locked, then tone_in held low -> tone_present goes to 0 when cnt reaches 48482, state = IDLE, no period_valid pulse.
REQ-032 Scenario: rst pulsed for 1 cycle while locked -> the next cycle shows tone_present=0, period=0, period_valid=0; lock returns only after 5 further nominal edges.
REQ-033 Scenario: edge arriving exactly at cnt=48482 -> period=48483 with period_valid=1, state MEASURE (not IDLE), good_cnt=0.
